// File: rtl/mulmod_arbiter_if.sv
// Bus between the arbiter and the shared modular multiplier.
// The arbiter drives start/operands (master); the multiplier returns result and done level (slave).
interface mulmod_arbiter_if #(
  parameter int W = 32
);
  logic         mul_start;
  logic [W-1:0] mul_a;
  logic [W-1:0] mul_b;
  logic [W-1:0] mul_m;
  logic [W-1:0] mul_result;
  logic         mul_done;

  modport master (
    output mul_start, mul_a, mul_b, mul_m,
    input  mul_result, mul_done
  );

  modport slave (
    input  mul_start, mul_a, mul_b, mul_m,
    output mul_result, mul_done
  );
endinterface

// File: rtl/mulmod_arbiter.sv
// Two-client round-robin arbiter in front of one shared modular multiplier.
// Each client holds one outstanding request; results and done flags are registered per client.
//
// Handshakes: a client request is taken when ci_start and ci_done are both 1 at a rising edge;
// the multiplier is started by a one-cycle mul_start pulse and is sampled through its mul_done level.
module mulmod_arbiter #(
  parameter int W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             c0_start,
  input  logic             c1_start,
  input  logic [W-1:0]     c0_a,
  input  logic [W-1:0]     c0_b,
  input  logic [W-1:0]     c0_m,
  input  logic [W-1:0]     c1_a,
  input  logic [W-1:0]     c1_b,
  input  logic [W-1:0]     c1_m,
  output logic [W-1:0]     c0_result,
  output logic [W-1:0]     c1_result,
  output logic             c0_done,
  output logic             c1_done,
  mulmod_arbiter_if.master mul,
  output logic             busy,
  output logic             grant,
  output logic [1:0]       dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    CLEAR = 2'd2,
    WAIT  = 2'd3
  } state_e;

  state_e              state_q;
  logic                p_q;
  logic [1:0]          pending_q;
  logic [1:0]          done_q;
  logic [1:0][W-1:0]   op_a_q;
  logic [1:0][W-1:0]   op_b_q;
  logic [1:0][W-1:0]   op_m_q;
  logic [1:0][W-1:0]   result_q;
  logic                mul_start_q;
  logic [W-1:0]        mul_a_q;
  logic [W-1:0]        mul_b_q;
  logic [W-1:0]        mul_m_q;
  logic                grant_q;
  logic                busy_q;

  logic [1:0]          start_d;
  logic [1:0]          accept_d;
  logic [1:0][W-1:0]   a_d;
  logic [1:0][W-1:0]   b_d;
  logic [1:0][W-1:0]   m_d;
  logic                winner_d;

  assign start_d  = {c1_start, c0_start};
  assign accept_d = start_d & done_q;
  assign a_d      = {c1_a, c0_a};
  assign b_d      = {c1_b, c0_b};
  assign m_d      = {c1_m, c0_m};

  // With both pending the pointer decides; otherwise the single pending client wins.
  assign winner_d = (&pending_q) ? p_q : ~pending_q[0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      p_q         <= 1'b0;
      pending_q   <= '0;
      done_q      <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      op_m_q      <= '0;
      result_q    <= '0;
      mul_start_q <= 1'b0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      mul_m_q     <= '0;
      grant_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (accept_d[i]) begin
          op_a_q[i]    <= a_d[i];
          op_b_q[i]    <= b_d[i];
          op_m_q[i]    <= m_d[i];
          pending_q[i] <= 1'b1;
          done_q[i]    <= 1'b0;
        end else if (!pending_q[i]) begin
          done_q[i]    <= 1'b1;
        end
      end

      case (state_q)
        IDLE: begin
          if (|pending_q) begin
            mul_a_q     <= op_a_q[winner_d];
            mul_b_q     <= op_b_q[winner_d];
            mul_m_q     <= op_m_q[winner_d];
            grant_q     <= winner_d;
            mul_start_q <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= ISSUE;
          end
        end
        ISSUE: begin
          mul_start_q <= 1'b0;
          state_q     <= CLEAR;
        end
        // One spare cycle so the multiplier can drop a stale mul_done before WAIT samples it.
        CLEAR: begin
          state_q <= WAIT;
        end
        WAIT: begin
          if (mul.mul_done) begin
            result_q[grant_q]  <= mul.mul_result;
            done_q[grant_q]    <= 1'b1;
            pending_q[grant_q] <= 1'b0;
            p_q                <= ~grant_q;
            busy_q             <= 1'b0;
            state_q            <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign c0_result     = result_q[0];
  assign c1_result     = result_q[1];
  assign c0_done       = done_q[0];
  assign c1_done       = done_q[1];
  assign mul.mul_start = mul_start_q;
  assign mul.mul_a     = mul_a_q;
  assign mul.mul_b     = mul_b_q;
  assign mul.mul_m     = mul_m_q;
  assign busy          = busy_q;
  assign grant         = grant_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_mulmod_arbiter.sv
// Bench for mulmod_arbiter: a latency-randomised multiplier model, a table of known
// vectors, hand sequences for the corner cases, and a random two-client phase.
module tb_mulmod_arbiter;
  localparam int W   = 32;
  localparam int LIM = 400;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic         c0_start, c1_start;
  logic [W-1:0] c0_a, c0_b, c0_m, c1_a, c1_b, c1_m;
  logic [W-1:0] c0_result, c1_result;
  logic         c0_done, c1_done, busy, grant;
  logic [1:0]   dbg_state;

  mulmod_arbiter_if #(.W(W)) mul ();

  mulmod_arbiter #(.W(W)) dut (
    .clk(clk), .reset(reset),
    .c0_start(c0_start), .c1_start(c1_start),
    .c0_a(c0_a), .c0_b(c0_b), .c0_m(c0_m),
    .c1_a(c1_a), .c1_b(c1_b), .c1_m(c1_m),
    .c0_result(c0_result), .c1_result(c1_result),
    .c0_done(c0_done), .c1_done(c1_done),
    .mul(mul),
    .busy(busy), .grant(grant), .dbg_state_o(dbg_state)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [W-1:0] mulmod(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [W-1:0] m);
    logic [63:0] p;
    p = (64'(a) * 64'(b)) % 64'(m);
    return p[W-1:0];
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- shared multiplier model ----------------
  int           mul_lat_force = 0;
  int           mul_cnt;
  logic [W-1:0] ma, mb, mm;
  always @(posedge clk) begin
    if (reset) begin
      mul.mul_done   <= 1'b0;
      mul.mul_result <= '0;
      mul_cnt        <= 0;
    end else if (mul.mul_start) begin
      mul.mul_done <= 1'b0;
      ma           <= mul.mul_a;
      mb           <= mul.mul_b;
      mm           <= mul.mul_m;
      mul_cnt      <= (mul_lat_force > 0) ? mul_lat_force : $urandom_range(1, 6);
    end else if (mul_cnt == 1) begin
      mul.mul_done   <= 1'b1;
      mul.mul_result <= mulmod(ma, mb, mm);
      mul_cnt        <= 0;
    end else if (mul_cnt > 1) begin
      mul_cnt <= mul_cnt - 1;
    end
  end

  // ---------------- reference model / scoreboard ----------------
  bit           pend [2];
  int           pend_cyc [2];
  logic [W-1:0] m_a [2], m_b [2], m_m [2];
  int           last_srv = 1;
  logic [W-1:0] exp_q0[$];
  logic [W-1:0] exp_q1[$];
  bit           gq[$];
  int           pulses = 0;
  int           done_cyc [2];
  logic         prev_done [2];
  logic         prev_start = 1'b0;
  logic [W-1:0] cap_a, cap_b, cap_m;
  logic         cap_g;

  function automatic logic done_of(input int c);
    return (c == 0) ? c0_done : c1_done;
  endfunction

  function automatic logic [W-1:0] result_of(input int c);
    return (c == 0) ? c0_result : c1_result;
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        pend[0] = 0; pend[1] = 0;
        exp_q0.delete(); exp_q1.delete();
        last_srv = 1;
        prev_done[0] = 1'b0; prev_done[1] = 1'b0;
        prev_start = 1'b0;
      end else begin
        if (mul.mul_start) begin
          bit e0, e1;
          int ew;
          pulses++;
          gq.push_back(grant);
          chk("mul_start_single_cycle", prev_start, 1'b0);
          // A request is visible to the arbiter two cycles after its start strobe was driven.
          e0 = pend[0] && (pend_cyc[0] <= cyc - 2);
          e1 = pend[1] && (pend_cyc[1] <= cyc - 2);
          chk("mul_start_has_request", e0 | e1, 1'b1);
          if (e0 || e1) begin
            ew = (e0 && e1) ? ((last_srv == 0) ? 1 : 0) : (e0 ? 0 : 1);
            chk("grant_round_robin", grant, ew[0]);
            chk("issued_operands", {mul.mul_a, mul.mul_b, mul.mul_m}, {m_a[ew], m_b[ew], m_m[ew]});
          end
          cap_a = mul.mul_a; cap_b = mul.mul_b; cap_m = mul.mul_m; cap_g = grant;
        end else if (busy) begin
          chk("operands_stable", {mul.mul_a, mul.mul_b, mul.mul_m, grant},
              {cap_a, cap_b, cap_m, cap_g});
        end
        for (int i = 0; i < 2; i++) begin
          if (done_of(i) && !prev_done[i] && pend[i]) begin
            logic [W-1:0] e;
            if (i == 0) begin
              chk("c0_exp_q_nonempty", exp_q0.size() > 0, 1'b1);
              e = (exp_q0.size() > 0) ? exp_q0.pop_front() : '0;
            end else begin
              chk("c1_exp_q_nonempty", exp_q1.size() > 0, 1'b1);
              e = (exp_q1.size() > 0) ? exp_q1.pop_front() : '0;
            end
            chk((i == 0) ? "c0_result_model" : "c1_result_model", result_of(i), e);
            pend[i]     = 0;
            last_srv    = i;
            done_cyc[i] = cyc;
          end
          prev_done[i] = done_of(i);
        end
        prev_start = mul.mul_start;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_client(input int c, input logic s, input logic [W-1:0] a,
                              input logic [W-1:0] b, input logic [W-1:0] m);
    if (c == 0) begin c0_start = s; c0_a = a; c0_b = b; c0_m = m; end
    else        begin c1_start = s; c1_a = a; c1_b = b; c1_m = m; end
  endtask

  task automatic start_client(input int c, input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic [W-1:0] m);
    int t = 0;
    @(negedge clk);
    while (!done_of(c) && t < LIM) begin
      @(negedge clk);
      t++;
    end
    chk("start_wait_done_timeout", t < LIM, 1'b1);
    @(posedge clk); #1;
    drive_client(c, 1'b1, a, b, m);
    pend[c] = 1; pend_cyc[c] = cyc;
    m_a[c] = a; m_b[c] = b; m_m[c] = m;
    if (c == 0) exp_q0.push_back(mulmod(a, b, m));
    else        exp_q1.push_back(mulmod(a, b, m));
    @(posedge clk); #1;
    if (c == 0) c0_start = 1'b0; else c1_start = 1'b0;
  endtask

  task automatic wait_done(input int c);
    int t = 0;
    @(negedge clk);
    while (!done_of(c) && t < LIM) begin
      @(negedge clk);
      t++;
    end
    chk("wait_done_timeout", t < LIM, 1'b1);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic chk_all_zero(input string nm);
    chk(nm, {c0_result, c1_result, c0_done, c1_done, mul.mul_start, mul.mul_a, mul.mul_b,
             mul.mul_m, grant, busy}, '0);
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    int           c;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] m;
    logic [W-1:0] r;
  } vec_t;

  vec_t tbl [8];

  initial begin
    #600000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1);
  end

  initial begin
    int p0;
    tbl[0] = '{0, 32'd3, 32'd5, 32'd7, 32'd1};
    tbl[1] = '{1, 32'd10, 32'd10, 32'd7, 32'd2};
    tbl[2] = '{0, 32'd0, 32'd123, 32'd97, 32'd0};
    tbl[3] = '{1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0};
    tbl[4] = '{0, 32'd12345, 32'd6789, 32'd1000, 32'd205};
    tbl[5] = '{1, 32'd7, 32'd8, 32'd1, 32'd0};
    tbl[6] = '{0, 32'd1, 32'd1, 32'hFFFF_FFFF, 32'd1};
    tbl[7] = '{1, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd1};

    reset = 1'b1;
    drive_client(0, 1'b0, '0, '0, 32'd1);
    drive_client(1, 1'b0, '0, '0, 32'd1);

    // Reset values, then done rises in the first non-reset cycle.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset_outputs");
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("done_low_until_first_edge", {c0_done, c1_done}, 2'b00);
    @(posedge clk);
    @(negedge clk);
    chk("done_after_reset", {c0_done, c1_done}, 2'b11);

    // Table of known vectors, one client at a time.
    for (int k = 0; k < 8; k++) begin
      p0 = pulses;
      start_client(tbl[k].c, tbl[k].a, tbl[k].b, tbl[k].m);
      @(negedge clk);
      chk("other_client_idle", done_of(1 - tbl[k].c), 1'b1);
      wait_done(tbl[k].c);
      chk("tbl_result", result_of(tbl[k].c), tbl[k].r);
      chk("tbl_one_pulse", pulses - p0, 1);
    end

    // Simultaneous starts right after reset: c0 first, then c1.
    do_reset();
    p0 = pulses;
    fork
      start_client(0, 32'd11, 32'd13, 32'd17);
      start_client(1, 32'd19, 32'd23, 32'd29);
    join
    wait_done(0);
    wait_done(1);
    chk("both_two_pulses", pulses - p0, 2);
    chk("c0_served_first", done_cyc[0] < done_cyc[1], 1'b1);
    chk("both_c0_result", c0_result, 32'd7);
    chk("both_c1_result", c1_result, 32'd2);

    // c1 requests while c0 is waiting on a slow multiplier.
    mul_lat_force = 8;
    start_client(0, 32'd100, 32'd200, 32'd301);
    repeat (3) @(posedge clk);
    start_client(1, 32'd5, 32'd6, 32'd31);
    wait_done(0);
    wait_done(1);
    chk("slow_c0_result", c0_result, 32'd134);
    chk("slow_c1_result", c1_result, 32'd30);

    // Starts while done=0 (including the completion cycle) are ignored.
    mul_lat_force = 6;
    p0 = pulses;
    start_client(0, 32'd9, 32'd9, 32'd10);
    @(posedge clk); #1;
    drive_client(0, 1'b1, 32'd2, 32'd2, 32'd3);
    repeat (2) @(posedge clk);
    #1;
    c0_start = 1'b0;
    begin
      int t = 0;
      @(negedge clk);
      while (!(busy && mul.mul_done && !mul.mul_start) && t < LIM) begin
        @(negedge clk);
        t++;
      end
      chk("completion_cycle_timeout", t < LIM, 1'b1);
    end
    c0_start = 1'b1;
    @(posedge clk); #1;
    c0_start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("ignored_no_extra_pulse", pulses - p0, 1);
    chk("ignored_c0_done", c0_done, 1'b1);
    chk("ignored_c0_result", c0_result, 32'd1);

    // Reset while in WAIT aborts without a result write.
    mul_lat_force = 20;
    do_reset();
    @(posedge clk); @(posedge clk);
    p0 = pulses;
    start_client(0, 32'd3, 32'd4, 32'd5);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("in_wait_busy", busy, 1'b1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset_in_wait_outputs");
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("abort_done_after_reset", {c0_done, c1_done}, 2'b11);
    repeat (25) @(posedge clk);
    @(negedge clk);
    chk("abort_no_result", c0_result, '0);
    chk("abort_pulse_count", pulses - p0, 1);
    mul_lat_force = 0;

    // Random traffic from both clients against the model.
    fork
      begin
        for (int k = 0; k < 25; k++) begin
          start_client(0, $urandom, $urandom, $urandom_range(32'hFFFF_FFFF, 1));
          repeat ($urandom_range(0, 3)) @(posedge clk);
        end
      end
      begin
        for (int k = 0; k < 25; k++) begin
          start_client(1, $urandom, $urandom, $urandom_range(32'hFFFF_FFFF, 1));
          repeat ($urandom_range(0, 3)) @(posedge clk);
        end
      end
    join
    wait_done(0);
    wait_done(1);

    // Both clients restarting as soon as possible: grants must alternate.
    gq.delete();
    fork
      for (int k = 0; k < 10; k++) start_client(0, $urandom, $urandom, $urandom_range(1000, 1));
      for (int k = 0; k < 10; k++) start_client(1, $urandom, $urandom, $urandom_range(1000, 1));
    join
    wait_done(0);
    wait_done(1);
    chk("alternation_grant_count", gq.size(), 20);
    for (int k = 1; k < gq.size(); k++) chk("grant_alternates", gq[k] ^ gq[k-1], 1'b1);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mulmod_arbiter.md
MULMOD_ARBITER -- requirements
Module: mulmod_arbiter

Interface
REQ-001 SHALL have parameter: W, 32, operand/result width.
REQ-002 SHALL have ports: clk  in  1  clock; all state changes on rising edge.
REQ-003 SHALL have ports: reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have ports: c0_start, c1_start  in  1  client request strobes.
REQ-005 SHALL have ports: c0_a/c0_b/c0_m, c1_a/c1_b/c1_m  in  W  client operands (base, multiplier, modulus).
REQ-006 SHALL have ports: c0_result, c1_result  out  W  registered client results.
REQ-007 SHALL have ports: c0_done, c1_done  out  1  registered; 1 = client idle and result valid.
REQ-008 SHALL have ports: mul_start  out  1  start strobe to the shared modular multiplier.
REQ-009 SHALL have ports: mul_a, mul_b, mul_m  out  W  registered operands to the multiplier.
REQ-010 SHALL have ports: mul_result  in  W  multiplier result.
REQ-011 SHALL have ports: mul_done  in  1  multiplier done level.
REQ-012 SHALL have ports: busy  out  1  high in any state other than IDLE.
REQ-013 SHALL have ports: grant  out  1  index of the client owning the multiplier; valid while busy.

Function
REQ-014 Client i SHALL accept a request only when ci_start=1 and ci_done=1 in the same cycle; the start is otherwise ignored.
REQ-015 On acceptance, the block SHALL latch ci_a/ci_b/ci_m into per-client operand registers.
REQ-016 On acceptance, the block SHALL set pending[i] and drive ci_done<=0 the next cycle.
REQ-017 ci_done SHALL stay 0 until client i's result is written.
REQ-018 ci_result SHALL hold its last value until overwritten by completion.
REQ-019 The FSM SHALL have states IDLE, ISSUE, CLEAR and WAIT.
REQ-020 IDLE with no pending SHALL remain in IDLE.
REQ-021 IDLE with any pending SHALL select the winner, load mul_a/b/m from the winner's operand registers, set grant, set mul_start<=1, and go to ISSUE.
REQ-022 Winner selection SHALL be round-robin: priority pointer p; if both clients pend, p wins; if one pends, it wins.
REQ-023 ISSUE SHALL set mul_start<=0 and go to CLEAR; mul_start SHALL be high for exactly one cycle per grant.
REQ-024 CLEAR SHALL go to WAIT unconditionally; this allows the multiplier to drop mul_done.
REQ-025 WAIT SHALL remain while mul_done=0.
REQ-026 WAIT with mul_done=1 SHALL write c[grant]_result<=mul_result, c[grant]_done<=1, pending[grant]<=0, p<=~grant, and go to IDLE.
REQ-027 Latency from an accepted start at edge T with the multiplier free SHALL be mul_start high during cycle T+2; ci_done rises one cycle after mul_done is sampled in WAIT.
REQ-028 Back-to-back grants SHALL be supported: a request pending at completion is issued from the IDLE cycle immediately following.
REQ-029 A start from client i in the cycle its completion is written SHALL be ignored, because ci_done is still 0.
REQ-030 When both clients start in the same cycle, both SHALL be accepted; service order follows p.
REQ-031 mul_a/b/m and grant SHALL be held stable from ISSUE through WAIT.
REQ-032 A client's own new request SHALL NOT alter operands already issued to the multiplier.

Reset
REQ-033 On reset, the FSM SHALL go to IDLE and p SHALL be set to 0.
REQ-034 On reset, pending SHALL be 0, and mul_start, mul_a, mul_b, mul_m, grant and busy SHALL be 0.
REQ-035 On reset, c0_result, c1_result, c0_done and c1_done SHALL be 0.
REQ-036 In the first non-reset cycle, ci_done SHALL become 1 if no request is pending.
REQ-037 Reset mid-transaction SHALL abort the transaction, with no result written and mul_start low.
REQ-038 The shared multiplier SHALL be reset by the same reset.

Verification
REQ-039 Scenario: c0 start with a=3, b=5, m=7, multiplier model returns 1 -> mul_start single pulse with mul_a=3, mul_b=5, mul_m=7; c0_result=1, c0_done=1; c1_done stays 1.
REQ-040 Scenario: c0 and c1 start in the same cycle after reset -> c0 served first, then c1 issued from the next IDLE cycle; exactly two mul_start pulses.
REQ-041 Scenario: both clients continuously restarting -> grants alternate 0,1,0,1; neither client starves.
REQ-042 Scenario: c1 starts while c0 is in WAIT with different operands -> mul_a/b/m unchanged until c0 completes; then c1 operands issued.
REQ-043 Scenario: start asserted while ci_done=0, including the completion cycle -> ignored, no extra transaction.
REQ-044 Scenario: reset asserted in WAIT -> all outputs 0 next cycle, ci_done=1 one cycle after reset drops, no result write.
